fifo_lane_unpacker: RTL and testbench

- Read-side companion to the team's registered SRL FIFO.
- Pops wide words from the FIFO's EMPTY_N/D_OUT/DEQ interface and serialises each word, lane by lane, onto a narrow valid/ready stream with first/last markers.
- Sits between a wide FIFO and a narrow consumer such as a byte-lane egress or a link serialiser.
- Sustains one lane per cycle with no bubble between consecutive words.

---
 rtl/fifo_lane_unpacker.sv | 83 ++++++++
 tb/tb_fifo_lane_unpacker.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_lane_unpacker.sv
// Read-side companion to the registered SRL FIFO: pops wide words and replays
// them lane by lane on a narrow valid/ready stream with first/last markers.
module fifo_lane_unpacker #(
  parameter int width = 128,
  parameter int lanes = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CLR,
  input  logic                     F_EMPTY_N,
  input  logic [width-1:0]         F_D_OUT,
  output logic                     F_DEQ,
  output logic                     S_VALID,
  input  logic                     S_READY,
  output logic [width/lanes-1:0]   S_DATA,
  output logic                     S_FIRST,
  output logic                     S_LAST,
  output logic [15:0]              WORD_CNT
);

  localparam int LW    = width / lanes;
  localparam int IDX_W = (lanes > 1) ? $clog2(lanes) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(lanes - 1);

  logic [width-1:0] hreg;
  logic             hvalid;
  logic [IDX_W-1:0] idx;
  logic [15:0]      cnt;

  logic at_last;
  logic xfer;

  assign at_last = (idx == LAST_IDX);
  assign xfer    = hvalid && S_READY;

  // The next word is popped in the same cycle the last lane leaves, which is
  // what removes the bubble between words; reset gates the pop so the FIFO is
  // never drained while this block is held in reset.
  assign F_DEQ = RST_N && F_EMPTY_N && !CLR && (!hvalid || (S_READY && at_last));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the holding register is reset as well so S_DATA reads zero out
      // of reset; it carries no reset otherwise needed for correctness.
      hreg   <= '0;
      hvalid <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
    end else if (CLR) begin
      hvalid <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
    end else if (F_DEQ) begin
      hreg   <= F_D_OUT;
      hvalid <= 1'b1;
      idx    <= '0;
      cnt    <= cnt + 16'd1;
    end else if (xfer && !at_last) begin
      idx    <= idx + IDX_W'(1);
    end else if (xfer) begin
      hvalid <= 1'b0;
      idx    <= '0;
    end
  end

  generate
    if (lanes == 1) begin : g_single
      assign S_DATA = hreg;
    end else begin : g_multi
      logic [lanes-1:0][LW-1:0] lane_view;
      assign lane_view = hreg;
      assign S_DATA    = lane_view[idx];
    end
  endgenerate

  assign S_VALID  = hvalid;
  assign S_FIRST  = (idx == '0);
  assign S_LAST   = at_last;
  assign WORD_CNT = cnt;

endmodule

// File: tb/tb_fifo_lane_unpacker.sv
// Directed bench for fifo_lane_unpacker: a 32-bit/4-lane instance checked
// against a FIFO model and lane scoreboard, plus a 16-bit/1-lane wrap run.
module tb_fifo_lane_unpacker;

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
  } lane_t;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        f_empty_n;
  logic [31:0] f_d_out;
  logic        f_deq;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_first;
  logic        s_last;
  logic [15:0] word_cnt;

  logic        clr1;
  logic        f_empty_n1;
  logic [15:0] f_d_out1;
  logic        f_deq1;
  logic        s_valid1;
  logic        s_ready1;
  logic [15:0] s_data1;
  logic        s_first1;
  logic        s_last1;
  logic [15:0] word_cnt1;

  fifo_lane_unpacker #(.width(32), .lanes(4)) dut (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .F_EMPTY_N(f_empty_n), .F_D_OUT(f_d_out), .F_DEQ(f_deq),
    .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
    .S_FIRST(s_first), .S_LAST(s_last), .WORD_CNT(word_cnt)
  );

  fifo_lane_unpacker #(.width(16), .lanes(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr1),
    .F_EMPTY_N(f_empty_n1), .F_D_OUT(f_d_out1), .F_DEQ(f_deq1),
    .S_VALID(s_valid1), .S_READY(s_ready1), .S_DATA(s_data1),
    .S_FIRST(s_first1), .S_LAST(s_last1), .WORD_CNT(word_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] fifo_q[$];
  lane_t       exp_q[$];
  logic [15:0] q1[$];
  logic [15:0] cnt_model;

  logic       smp_valid, smp_deq, smp_first, smp_last, smp_clr, smp_empty_n;
  logic [7:0] smp_data;
  logic [15:0] smp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_fifo();
    f_empty_n = (fifo_q.size() != 0);
    f_d_out   = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic push_word(input logic [31:0] w);
    lane_t l;
    fifo_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      l.data  = w[i*8 +: 8];
      l.first = (i == 0);
      l.last  = (i == 3);
      exp_q.push_back(l);
    end
    refresh_fifo();
  endtask

  task automatic drop_lanes(input int n);
    for (int i = 0; i < n; i++) void'(exp_q.pop_front());
  endtask

  // One clock: sample on the falling edge, score any transfer, then apply the
  // FIFO pop / counter update just after the rising edge.
  task automatic step();
    lane_t e;
    @(negedge clk);
    smp_valid   = s_valid;
    smp_deq     = f_deq;
    smp_first   = s_first;
    smp_last    = s_last;
    smp_data    = s_data;
    smp_cnt     = word_cnt;
    smp_clr     = clr;
    smp_empty_n = f_empty_n;
    if (s_valid && s_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_lane", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("sb_data",  s_data,  e.data);
        check("sb_first", s_first, e.first);
        check("sb_last",  s_last,  e.last);
      end
    end
    if (!smp_empty_n) check("deq_when_empty", smp_deq, 0);
    check("word_cnt", smp_cnt, cnt_model);
    @(posedge clk);
    #1;
    if (smp_clr) begin
      cnt_model = 16'd0;
    end else if (smp_deq) begin
      cnt_model = cnt_model + 16'd1;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    refresh_fifo();
  endtask

  task automatic cyc(input string tag, input logic v, input logic d);
    step();
    check({tag, "_valid"}, smp_valid, v);
    check({tag, "_deq"},   smp_deq,   d);
  endtask

  int  pops;
  logic deq1;
  logic [15:0] w1;

  initial begin
    rst_n = 1'b0; clr = 1'b0; s_ready = 1'b0;
    clr1 = 1'b0; f_empty_n1 = 1'b0; f_d_out1 = 16'h0; s_ready1 = 1'b0;
    cnt_model = 16'd0;
    refresh_fifo();

    // Reset state, with a word already waiting: no pop may happen in reset.
    #3;
    push_word(32'h44332211);
    #1;
    check("rst_valid", s_valid, 0);
    check("rst_data",  s_data, 0);
    check("rst_first", s_first, 1);
    check("rst_last",  s_last, 0);
    check("rst_cnt",   word_cnt, 0);
    check("rst_deq",   f_deq, 0);
    check("rst1_first", s_first1, 1);
    check("rst1_last",  s_last1, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_ready = 1'b1;

    // Basic serialisation.
    cyc("t1_c1", 0, 1);
    cyc("t1_c2", 1, 0);
    check("t1_first", smp_first, 1);
    cyc("t1_c3", 1, 0);
    cyc("t1_c4", 1, 0);
    cyc("t1_c5", 1, 0);
    check("t1_last", smp_last, 1);
    cyc("t1_c6", 0, 0);
    check("t1_cnt", smp_cnt, 1);

    // Back-to-back words: second pop on the 0x44 transfer, no bubble.
    push_word(32'h44332211);
    push_word(32'h88776655);
    cyc("t2_c1", 0, 1);
    for (int i = 0; i < 3; i++) cyc("t2_w0", 1, 0);
    cyc("t2_c5", 1, 1);
    for (int i = 0; i < 4; i++) cyc("t2_w1", 1, 0);
    cyc("t2_end", 0, 0);

    // Backpressure mid-word and on the last lane.
    push_word(32'h44332211);
    push_word(32'h88776655);
    cyc("t3_c1", 0, 1);
    cyc("t3_c2", 1, 0);
    s_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("t3_stall", 1, 0);
      check("t3_hold_data", smp_data, 8'h22);
    end
    s_ready = 1'b1;
    cyc("t3_c6", 1, 0);
    cyc("t3_c7", 1, 0);
    s_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc("t3_stall_last", 1, 0);
      check("t3_hold_last", smp_data, 8'h44);
      check("t3_last_flag", smp_last, 1);
    end
    s_ready = 1'b1;
    cyc("t3_c10", 1, 1);
    for (int i = 0; i < 4; i++) cyc("t3_w1", 1, 0);
    cyc("t3_end", 0, 0);

    // Empty FIFO, then a word arrives.
    for (int i = 0; i < 10; i++) cyc("t4_empty", 0, 0);
    push_word(32'hDDCCBBAA);
    cyc("t4_c1", 0, 1);
    cyc("t4_c2", 1, 0);
    check("t4_first_data", smp_data, 8'hAA);
    for (int i = 0; i < 3; i++) cyc("t4_rest", 1, 0);
    cyc("t4_end", 0, 0);

    // CLR mid-word while 0x33 is presented; CLR held one extra idle cycle.
    push_word(32'h44332211);
    push_word(32'h88776655);
    cyc("t5_c1", 0, 1);
    cyc("t5_c2", 1, 0);
    cyc("t5_c3", 1, 0);
    s_ready = 1'b0;
    clr = 1'b1;
    cyc("t5_clr", 1, 0);
    check("t5_clr_data", smp_data, 8'h33);
    drop_lanes(2);
    cyc("t5_clr_idle", 0, 0);
    check("t5_cnt_cleared", smp_cnt, 0);
    clr = 1'b0;
    s_ready = 1'b1;
    cyc("t5_c6", 0, 1);
    cyc("t5_c7", 1, 0);
    check("t5_restart_first", smp_first, 1);
    for (int i = 0; i < 3; i++) cyc("t5_rest", 1, 0);
    cyc("t5_end", 0, 0);

    // Asynchronous reset while the last lane is offered with a pop pending.
    push_word(32'h44332211);
    push_word(32'hCAFEF00D);
    cyc("t6_c1", 0, 1);
    for (int i = 0; i < 3; i++) cyc("t6_lane", 1, 0);
    #2;
    check("t6_pre_deq",  f_deq, 1);
    check("t6_pre_data", s_data, 8'h44);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", s_valid, 0);
    check("t6_rst_deq",   f_deq, 0);
    check("t6_rst_data",  s_data, 0);
    check("t6_rst_first", s_first, 1);
    check("t6_rst_cnt",   word_cnt, 0);
    drop_lanes(1);
    cnt_model = 16'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("t6_c1b", 0, 1);
    for (int i = 0; i < 4; i++) cyc("t6_w1", 1, 0);
    cyc("t6_end", 0, 0);
    check("sb_drain", exp_q.size(), 0);

    // Single-lane instance: pop every cycle until WORD_CNT wraps.
    pops = 0;
    f_empty_n1 = 1'b1;
    f_d_out1 = 16'h0000;
    s_ready1 = 1'b1;
    for (int c = 0; c < 70000 && pops < 65536; c++) begin
      @(negedge clk);
      if (pops < 4 || pops > 65532) check("w_cnt", word_cnt1, 32'(pops[15:0]));
      if (s_valid1 && s_ready1) begin
        if (q1.size() == 0) begin
          check("w_unexpected", q1.size(), 1);
        end else begin
          w1 = q1.pop_front();
          if (w1 < 16'd32 || w1 > 16'd65500) begin
            check("w_data",  s_data1, w1);
            check("w_first", s_first1, 1);
            check("w_last",  s_last1, 1);
          end
        end
      end
      deq1 = f_deq1;
      if (deq1) q1.push_back(f_d_out1);
      @(posedge clk);
      #1;
      if (deq1) begin
        pops++;
        f_d_out1 = f_d_out1 + 16'd1;
      end
    end
    check("w_pops", pops, 65536);
    f_empty_n1 = 1'b0;
    @(negedge clk);
    check("w_wrapped_cnt", word_cnt1, 0);
    check("w_tail_valid", s_valid1, 1);
    check("w_tail_data", s_data1, 16'hFFFF);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("w_idle_valid", s_valid1, 0);
    check("w_idle_deq", f_deq1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
